// File: rtl/wb_pkg.sv
// wb_pkg: shared sizing and types for the writeback arbiter slice.
//   DATA_WIDTH  - width of a writeback result
//   REG_COUNT   - number of architectural registers
//   ADDR_WIDTH  - register index width
//   grant_e     - which source won the last transfer
package wb_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int REG_COUNT  = 32;
  localparam int ADDR_WIDTH = $clog2(REG_COUNT);

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LSU = 1'b1
  } grant_e;

endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: one busy bit per register marking a write still in flight,
// plus the decode-side hazard lookup.
//   set_valid/set_rd  - instruction issued with this destination
//   clr_valid/clr_rd  - writeback transfer for this destination
//   flush             - forget every pending write
//   wb_we/wb_rd       - register-file write happening this cycle
//   chk_rs1/chk_rs2   - decode source registers
//   hazard_rs1/rs2    - source not yet readable from the register file
module wb_scoreboard #(
  parameter  int REG_COUNT  = 32,
  localparam int ADDR_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_valid,
  input  logic [ADDR_WIDTH-1:0] set_rd,
  input  logic                  clr_valid,
  input  logic [ADDR_WIDTH-1:0] clr_rd,
  input  logic                  flush,
  input  logic                  wb_we,
  input  logic [ADDR_WIDTH-1:0] wb_rd,
  input  logic [ADDR_WIDTH-1:0] chk_rs1,
  input  logic [ADDR_WIDTH-1:0] chk_rs2,
  output logic                  hazard_rs1,
  output logic                  hazard_rs2
);

  logic [REG_COUNT-1:0] busy_q;
  logic [REG_COUNT-1:0] busy_d;

  // Order matters: clear first so a same-edge issue re-marks the register,
  // then flush wipes everything including that issue.
  always_comb begin
    // NOTE: start from the held value so every path assigns busy_d; no latch.
    busy_d = busy_q;
    if (clr_valid) busy_d[clr_rd] = 1'b0;
    if (set_valid && (set_rd != '0)) busy_d[set_rd] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  // NOTE: the busy array is a handful of flops, not a RAM, so it is reset;
  // stale busy bits after reset would stall decode forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // A register stays unreadable through the cycle its value is being written.
  assign hazard_rs1 = (chk_rs1 != '0) &&
                      (busy_q[chk_rs1] || (wb_we && (wb_rd == chk_rs1)));
  assign hazard_rs2 = (chk_rs2 != '0) &&
                      (busy_q[chk_rs2] || (wb_we && (wb_rd == chk_rs2)));

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbitration of ALU and LSU results onto the single
// register-file write port, with pending-write tracking for decode.
//   alu_valid/rd/data, alu_ready - ALU writeback request and grant
//   lsu_valid/rd/data, lsu_ready - load-unit writeback request and grant
//   rf_we/rf_rd/rf_wdata         - registered register-file write port
//   issue_valid/issue_rd         - destination becoming pending
//   flush                        - discard all pending-write tracking
//   chk_rs1/2, hazard_rs1/2      - decode hazard query
module wb_arbiter #(
  parameter  int DATA_WIDTH = wb_pkg::DATA_WIDTH,
  parameter  int REG_COUNT  = wb_pkg::REG_COUNT,
  localparam int ADDR_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] chk_rs1,
  input  logic [ADDR_WIDTH-1:0] chk_rs2,
  output logic                  hazard_rs1,
  output logic                  hazard_rs2
);

  import wb_pkg::*;

  grant_e                last_grant_q, last_grant_d;
  logic                  rf_we_q, rf_we_d;
  logic [ADDR_WIDTH-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  logic                  alu_fire, lsu_fire;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] xfer_rd;
  logic [DATA_WIDTH-1:0] xfer_data;

  // Under contention the source that did not win last time goes next.
  assign alu_ready = alu_valid && (!lsu_valid || (last_grant_q == GNT_LSU));
  assign lsu_ready = lsu_valid && (!alu_valid || (last_grant_q == GNT_ALU));

  assign alu_fire  = alu_valid && alu_ready;
  assign lsu_fire  = lsu_valid && lsu_ready;
  assign xfer      = alu_fire || lsu_fire;
  assign xfer_rd   = alu_fire ? alu_rd   : lsu_rd;
  assign xfer_data = alu_fire ? alu_data : lsu_data;

  always_comb begin
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_wdata_d   = rf_wdata_q;
    if (alu_fire)      last_grant_d = GNT_ALU;
    else if (lsu_fire) last_grant_d = GNT_LSU;
    // r0 writes complete the handshake but never reach the register file.
    if (xfer && (xfer_rd != '0)) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = xfer_rd;
      rf_wdata_d = xfer_data;
    end
  end

  // Reset to LSU so the first contended cycle favours the ALU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GNT_LSU;
      rf_we_q      <= 1'b0;
      rf_rd_q      <= '0;
      rf_wdata_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_rd_q      <= rf_rd_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;

  wb_scoreboard #(
    .REG_COUNT (REG_COUNT)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_valid  (issue_valid),
    .set_rd     (issue_rd),
    .clr_valid  (xfer),
    .clr_rd     (xfer_rd),
    .flush      (flush),
    .wb_we      (rf_we_q),
    .wb_rd      (rf_rd_q),
    .chk_rs1    (chk_rs1),
    .chk_rs2    (chk_rs2),
    .hazard_rs1 (hazard_rs1),
    .hazard_rs2 (hazard_rs2)
  );

endmodule
